// File: rtl/mem_channel_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : mem_channel_arbiter_if                                        |
// | Purpose  : Bundles the consumer-side and memory-side valid/ready buses   |
// |            of the memory channel arbiter.                                |
// | Ports    : none (signal container)                                       |
// |   consumer_read_*  : per-LSU read request/completion (packed per LSU)    |
// |   consumer_write_* : per-LSU write request/completion (packed per LSU)   |
// |   mem_read_*       : single read port toward memory                      |
// |   mem_write_*      : single write port toward memory                     |
// | Modports : master - the arbiter (issues memory requests, answers LSUs)   |
// |            slave  - the environment (LSUs plus memory model)             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface mem_channel_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    output consumer_read_ready, consumer_read_data,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    input  consumer_read_ready, consumer_read_data,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface
`default_nettype wire

// File: rtl/mem_channel_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : mem_channel_arbiter                                           |
// | Purpose  : Shares one memory channel (one read port, one write port)     |
// |            between NUM_CONSUMERS LSUs with round-robin arbitration.      |
// |            One transaction in flight at a time; all outputs registered.  |
// | Ports    :                                                               |
// |   clk      in   rising-edge clock                                        |
// |   reset    in   synchronous, active-low reset                            |
// |   bus      ifc  mem_channel_arbiter_if.master (consumer + memory buses)  |
// |   busy     out  high whenever the controller is not idle                 |
// |   grant_id out  index of the consumer currently (last) served            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_channel_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  wire                               clk,
  input  wire                               reset,
  mem_channel_arbiter_if.master             bus,
  output logic                              busy,
  output logic [$clog2(NUM_CONSUMERS)-1:0]  grant_id
);

  localparam int GRANT_BITS = $clog2(NUM_CONSUMERS);
  localparam logic [GRANT_BITS:0]   NUM_WIDE = (GRANT_BITS+1)'(NUM_CONSUMERS);
  localparam logic [GRANT_BITS-1:0] LAST_ID  = GRANT_BITS'(NUM_CONSUMERS - 1);
  localparam logic [NUM_CONSUMERS-1:0] ONE_HOT_ZERO = NUM_CONSUMERS'(1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_RELEASE    = 2'd3
  } state_t;

  state_t                  state;
  logic [GRANT_BITS-1:0]   rr_ptr;
  logic                    is_write;
  logic [NUM_CONSUMERS-1:0] rd_ready;
  logic [NUM_CONSUMERS-1:0] wr_ready;
  logic                    mem_rd_valid;
  logic [ADDR_BITS-1:0]    mem_rd_addr;
  logic                    mem_wr_valid;
  logic [ADDR_BITS-1:0]    mem_wr_addr;
  logic [DATA_BITS-1:0]    mem_wr_data;
  logic [DATA_BITS-1:0]    rd_data [NUM_CONSUMERS];

  // Unpacked views of the packed consumer buses, indexable by a grant index.
  logic [ADDR_BITS-1:0]    rd_addr_arr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]    wr_addr_arr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]    wr_data_arr [NUM_CONSUMERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_unpack
      assign rd_addr_arr[gi] = bus.consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_addr_arr[gi] = bus.consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
      assign wr_data_arr[gi] = bus.consumer_write_data[gi*DATA_BITS +: DATA_BITS];
      assign bus.consumer_read_data[gi*DATA_BITS +: DATA_BITS] = rd_data[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Round-robin search. The request vector is rotated so that bit 0 is the
  // consumer at rr_ptr; the lowest set bit of the rotated vector is then
  // the winner's distance from rr_ptr.
  // ---------------------------------------------------------------------
  logic [NUM_CONSUMERS-1:0]   req;
  logic [2*NUM_CONSUMERS-1:0] req_twice;
  logic [NUM_CONSUMERS-1:0]   req_rot;
  logic [NUM_CONSUMERS-1:0]   scan;
  logic [GRANT_BITS-1:0]      cand;
  logic [GRANT_BITS-1:0]      offset;
  logic                       found;
  logic [GRANT_BITS:0]        win_sum;
  logic [GRANT_BITS-1:0]      winner;
  logic [NUM_CONSUMERS-1:0]   winner_onehot;
  logic                       winner_reads;

  assign req       = bus.consumer_read_valid | bus.consumer_write_valid;
  assign req_twice = {req, req};
  assign req_rot   = NUM_CONSUMERS'(req_twice >> rr_ptr);

  always_comb begin
    scan   = req_rot;
    cand   = '0;
    offset = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (scan[0] && !found) begin
        found  = 1'b1;
        offset = cand;
      end
      scan = scan >> 1;
      cand = cand + 1'b1;
    end
  end

  always_comb begin
    win_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (win_sum >= NUM_WIDE) begin
      win_sum = win_sum - NUM_WIDE;
    end
  end

  assign winner        = win_sum[GRANT_BITS-1:0];
  assign winner_onehot = ONE_HOT_ZERO << winner;
  // A consumer raising both valids is served as a read first.
  assign winner_reads  = |(bus.consumer_read_valid & winner_onehot);

  // ---------------------------------------------------------------------
  // Grant-side helpers
  // ---------------------------------------------------------------------
  logic [NUM_CONSUMERS-1:0] grant_onehot;
  logic                     grantee_valid;
  logic [GRANT_BITS-1:0]    next_ptr;
  logic                     capture_read;

  assign grant_onehot  = ONE_HOT_ZERO << grant_id;
  assign grantee_valid = is_write ? |(bus.consumer_write_valid & grant_onehot)
                                  : |(bus.consumer_read_valid  & grant_onehot);
  assign next_ptr      = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign capture_read  = (state == ST_READ_WAIT) && bus.mem_read_ready;

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      busy         <= 1'b0;
      is_write     <= 1'b0;
      rd_ready     <= '0;
      wr_ready     <= '0;
      mem_rd_valid <= 1'b0;
      mem_rd_addr  <= '0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant_id <= winner;
            busy     <= 1'b1;
            if (winner_reads) begin
              is_write     <= 1'b0;
              mem_rd_valid <= 1'b1;
              mem_rd_addr  <= rd_addr_arr[winner];
              state        <= ST_READ_WAIT;
            end else begin
              is_write     <= 1'b1;
              mem_wr_valid <= 1'b1;
              mem_wr_addr  <= wr_addr_arr[winner];
              mem_wr_data  <= wr_data_arr[winner];
              state        <= ST_WRITE_WAIT;
            end
          end
        end

        ST_READ_WAIT: begin
          if (bus.mem_read_ready) begin
            mem_rd_valid <= 1'b0;
            rd_ready     <= grant_onehot;
            state        <= ST_RELEASE;
          end
        end

        ST_WRITE_WAIT: begin
          if (bus.mem_write_ready) begin
            mem_wr_valid <= 1'b0;
            wr_ready     <= grant_onehot;
            state        <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          // Completion stays visible until the served LSU withdraws its
          // request, so a slow LSU cannot miss it.
          if (!grantee_valid) begin
            rd_ready <= '0;
            wr_ready <= '0;
            rr_ptr   <= next_ptr;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-consumer read data holds until that consumer's next read returns.
  generate
    for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_rdata
      always_ff @(posedge clk) begin
        if (!reset) begin
          rd_data[gi] <= '0;
        end else if (capture_read && (grant_id == GRANT_BITS'(gi))) begin
          rd_data[gi] <= bus.mem_read_data;
        end
      end
    end
  endgenerate

  assign bus.consumer_read_ready  = rd_ready;
  assign bus.consumer_write_ready = wr_ready;
  assign bus.mem_read_valid       = mem_rd_valid;
  assign bus.mem_read_address     = mem_rd_addr;
  assign bus.mem_write_valid      = mem_wr_valid;
  assign bus.mem_write_address    = mem_wr_addr;
  assign bus.mem_write_data       = mem_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_channel_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_channel_arbiter                                        |
// | Purpose  : Directed self-checking bench for mem_channel_arbiter with a   |
// |            transaction-level reference model and scripted LSU/memory.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mem_channel_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_channel_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) bus ();
  logic          busy;
  logic [GW-1:0] grant_id;

  mem_channel_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: one current job, described by who/what/when done.
  // ------------------------------------------------------------------
  bit              m_active, m_done, m_isw, m_started, m_hit;
  int              m_cons, m_gid, m_rr, m_c;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata [N];
  logic [N-1:0]    e_rrdy, e_wrdy;
  logic [N*DW-1:0] e_rdata;
  bit              prev_busy;
  int              dut_log [$];

  always @(posedge clk) begin
    if (!reset) begin
      m_started = 1; m_active = 0; m_done = 0; m_isw = 0;
      m_cons = 0; m_gid = 0; m_rr = 0; m_addr = '0; m_wdata = '0;
      for (int i = 0; i < N; i++) m_rdata[i] = '0;
    end else if (!m_active) begin
      m_hit = 0;
      for (int k = 0; k < N; k++) begin
        m_c = (m_rr + k) % N;
        if (!m_hit && (bus.consumer_read_valid[m_c] || bus.consumer_write_valid[m_c])) begin
          m_hit = 1; m_active = 1; m_done = 0; m_cons = m_c; m_gid = m_c;
          m_isw   = !bus.consumer_read_valid[m_c];
          m_addr  = m_isw ? bus.consumer_write_address[m_c*AW +: AW]
                          : bus.consumer_read_address[m_c*AW +: AW];
          m_wdata = bus.consumer_write_data[m_c*DW +: DW];
        end
      end
    end else if (!m_done) begin
      if (m_isw ? bus.mem_write_ready : bus.mem_read_ready) begin
        m_done = 1;
        if (!m_isw) m_rdata[m_cons] = bus.mem_read_data;
      end
    end else if (!(m_isw ? bus.consumer_write_valid[m_cons] : bus.consumer_read_valid[m_cons])) begin
      m_active = 0;
      m_rr = (m_cons + 1) % N;
    end

    #1;
    if (m_started) begin
      e_rrdy = '0; e_wrdy = '0;
      if (m_active && m_done && !m_isw) e_rrdy[m_cons] = 1'b1;
      if (m_active && m_done &&  m_isw) e_wrdy[m_cons] = 1'b1;
      for (int i = 0; i < N; i++) e_rdata[i*DW +: DW] = m_rdata[i];
      chk("busy", busy, m_active);
      chk("grant_id", grant_id, m_gid[GW-1:0]);
      chk("mem_read_valid",  bus.mem_read_valid,  m_active && !m_done && !m_isw);
      chk("mem_write_valid", bus.mem_write_valid, m_active && !m_done &&  m_isw);
      if (m_active && !m_done && !m_isw) chk("mem_read_address", bus.mem_read_address, m_addr);
      if (m_active && !m_done && m_isw) begin
        chk("mem_write_address", bus.mem_write_address, m_addr);
        chk("mem_write_data", bus.mem_write_data, m_wdata);
      end
      chk("consumer_read_ready",  bus.consumer_read_ready,  e_rrdy);
      chk("consumer_write_ready", bus.consumer_write_ready, e_wrdy);
      chk("consumer_read_data",   bus.consumer_read_data,   e_rdata);
      if (busy && !prev_busy) dut_log.push_back(int'(grant_id));
      prev_busy = busy;
    end
  end

  // ------------------------------------------------------------------
  // Scripted LSUs and memory, advanced once per falling edge.
  // ------------------------------------------------------------------
  typedef struct {
    bit            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  op_t          cq [N][$];
  op_t          cur;
  logic [DW-1:0] mem [256];
  int           rd_lat, wr_lat, rd_cnt, wr_cnt;

  task automatic step();
    @(negedge clk);
    if (bus.mem_read_ready) bus.mem_read_ready = 1'b0;
    else if (bus.mem_read_valid) begin
      rd_cnt++;
      if (rd_cnt >= rd_lat) begin
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = mem[bus.mem_read_address];
        rd_cnt = 0;
      end
    end else rd_cnt = 0;

    if (bus.mem_write_ready) bus.mem_write_ready = 1'b0;
    else if (bus.mem_write_valid) begin
      wr_cnt++;
      if (wr_cnt >= wr_lat) begin
        bus.mem_write_ready = 1'b1;
        mem[bus.mem_write_address] = bus.mem_write_data;
        wr_cnt = 0;
      end
    end else wr_cnt = 0;

    for (int i = 0; i < N; i++) begin
      if ((bus.consumer_read_valid[i] && bus.consumer_read_ready[i]) ||
          (bus.consumer_write_valid[i] && bus.consumer_write_ready[i])) begin
        bus.consumer_read_valid[i]  = 1'b0;
        bus.consumer_write_valid[i] = 1'b0;
        cq[i].delete(0);
      end else if (!bus.consumer_read_valid[i] && !bus.consumer_write_valid[i] &&
                   !bus.consumer_read_ready[i] && !bus.consumer_write_ready[i] &&
                   cq[i].size() > 0) begin
        cur = cq[i][0];
        if (cur.w) begin
          bus.consumer_write_address[i*AW +: AW] = cur.a;
          bus.consumer_write_data[i*DW +: DW]    = cur.d;
          bus.consumer_write_valid[i]            = 1'b1;
        end else begin
          bus.consumer_read_address[i*AW +: AW] = cur.a;
          bus.consumer_read_valid[i]            = 1'b1;
        end
      end
    end
  endtask

  task automatic flush_env();
    for (int i = 0; i < N; i++) cq[i].delete();
    bus.consumer_read_valid    = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_read_data   = '0;
    bus.mem_write_ready = 1'b0;
    rd_cnt = 0; wr_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush_env();
    step();
    step();
    reset = 1'b1;
    dut_log.delete();
  endtask

  task automatic push(input int c, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.w = w; o.a = a; o.d = d;
    cq[c].push_back(o);
  endtask

  task automatic run_until_quiet(input string name, input int max_cycles);
    bit quiet;
    for (int n = 0; n < max_cycles; n++) begin
      step();
      quiet = !busy && (bus.consumer_read_valid == '0) && (bus.consumer_write_valid == '0);
      for (int i = 0; i < N; i++) if (cq[i].size() > 0) quiet = 0;
      if (quiet) return;
    end
    vectors++; miscompares++;
    $display("FAIL %s: timeout after %0d cycles, busy=%0b", name, max_cycles, busy);
  endtask

  task automatic wait_busy(input string name);
    for (int n = 0; n < 20; n++) begin
      if (busy) return;
      step();
    end
    vectors++; miscompares++;
    $display("FAIL %s: busy never rose, busy=%0b", name, busy);
  endtask

  // order: expected grant sequence, entry i in nibble i.
  task automatic chk_log(input string name, input int n, input logic [31:0] order);
    chk({name, "_count"}, dut_log.size(), n);
    for (int i = 0; i < n && i < dut_log.size(); i++)
      chk({name, "_grant"}, dut_log[i], order[i*4 +: 4]);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a * 3 + 1);
    mem[8'h10] = 8'hAB;
    rd_lat = 2; wr_lat = 2;
    flush_env();

    // Single read, memory answers two cycles after the request.
    do_reset();
    chk("reset_busy", busy, 1'b0);
    chk("reset_grant_id", grant_id, 2'd0);
    rd_lat = 2;
    push(0, 0, 8'h10, 8'h00);
    run_until_quiet("single_read", 100);
    chk("single_read_data", bus.consumer_read_data[7:0], 8'hAB);
    chk_log("single_read", 1, 32'h0);

    // Single write from consumer 3.
    do_reset();
    wr_lat = 3;
    push(3, 1, 8'h20, 8'h5C);
    run_until_quiet("single_write", 100);
    chk("single_write_mem", mem[8'h20], 8'h5C);
    chk_log("single_write", 1, 32'h3);

    // Round robin: 0,1,3 together; 0 re-requests while 1 is served.
    do_reset();
    rd_lat = 1;
    push(0, 0, 8'h01, 8'h00);
    push(0, 0, 8'h02, 8'h00);
    push(1, 0, 8'h03, 8'h00);
    push(3, 0, 8'h04, 8'h00);
    run_until_quiet("round_robin", 200);
    chk_log("round_robin", 4, 32'h0310);
    chk("rr_data0", bus.consumer_read_data[7:0], 8'h07);
    chk("rr_data3", bus.consumer_read_data[31:24], 8'h0D);

    // Fairness under continuous load from all four consumers.
    do_reset();
    rd_lat = 1;
    for (int i = 0; i < N; i++) begin
      push(i, 0, 8'(8'h30 + i), 8'h00);
      push(i, 0, 8'(8'h38 + i), 8'h00);
    end
    run_until_quiet("starvation", 400);
    chk_log("starvation", 8, 32'h3210_3210);

    // Memory stall: read ready held off for 20 cycles.
    do_reset();
    rd_lat = 22;
    push(2, 0, 8'h40, 8'h00);
    step();
    wait_busy("stall");
    for (int n = 0; n < 20; n++) begin
      step();
      if (n % 5 == 4) begin
        chk("stall_busy", busy, 1'b1);
        chk("stall_valid", bus.mem_read_valid, 1'b1);
        chk("stall_addr", bus.mem_read_address, 8'h40);
        chk("stall_ready", bus.consumer_read_ready, 4'h0);
      end
    end
    run_until_quiet("stall", 100);
    chk("stall_data2", bus.consumer_read_data[23:16], 8'hC1);

    // Reset while a read is waiting on memory.
    do_reset();
    rd_lat = 30;
    push(1, 0, 8'h33, 8'h00);
    step();
    wait_busy("reset_mid");
    step(); step(); step();
    reset = 1'b0;
    flush_env();
    step();
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_grant_id", grant_id, 2'd0);
    chk("rmid_rvalid", bus.mem_read_valid, 1'b0);
    chk("rmid_raddr", bus.mem_read_address, 8'h00);
    chk("rmid_rready", bus.consumer_read_ready, 4'h0);
    chk("rmid_rdata", bus.consumer_read_data, 32'h0);
    reset = 1'b1;
    dut_log.delete();
    rd_lat = 2;
    push(2, 0, 8'h44, 8'h00);
    run_until_quiet("reset_mid", 100);
    chk_log("reset_mid", 1, 32'h2);
    chk("rmid_data2", bus.consumer_read_data[23:16], 8'hCD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
- Shares one external memory channel (one read port plus one write port) between NUM_CONSUMERS load/store units using round-robin arbitration.
- Sits between the per-thread LSUs of one or more cores and the memory interface.
- On the consumer side it speaks the LSU valid/ready protocol: the consumer holds valid until it sees ready. On the memory side it speaks the same protocol toward memory.
- One transaction is in flight at a time; the block is fully registered.

Parameters:
NUM_CONSUMERS, 4, number of requesting LSUs (>=2)
ADDR_BITS, 8, memory address width
DATA_BITS, 8, memory data width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; consumer i at bits [i*ADDR_BITS +: ADDR_BITS]
consumer_read_ready  out  NUM_CONSUMERS  per-consumer read completion
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed per-consumer read data
consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed write address
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed write data
consumer_write_ready  out  NUM_CONSUMERS  per-consumer write completion
mem_read_valid  out  1  read request to memory
mem_read_address  out  ADDR_BITS  read address
mem_read_ready  in  1  memory read done; mem_read_data valid in the same cycle
mem_read_data  in  DATA_BITS  read data
mem_write_valid  out  1  write request to memory
mem_write_address  out  ADDR_BITS  write address
mem_write_data  out  DATA_BITS  write data
mem_write_ready  in  1  memory write done
busy  out  1  high whenever the FSM is not IDLE
grant_id  out  $clog2(NUM_CONSUMERS)  index of the consumer currently served

Behaviour:
- Reset (reset==0 at a clock edge): all outputs go to 0, FSM=IDLE, rr_ptr=0. Applies mid-transaction too: any in-flight transaction is abandoned, with no completion pulse.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RELEASE.
- IDLE:
  - req[i] = consumer_read_valid[i] | consumer_write_valid[i].
  - Search req starting at rr_ptr, ascending, wrapping modulo NUM_CONSUMERS; the first hit wins.
  - On a grant: latch grant_id and the winner's address (and data, for writes).
  - Read grant: mem_read_valid<=1, go to READ_WAIT.
  - Write grant: mem_write_valid<=1, go to WRITE_WAIT.
  - If a consumer asserts both read and write valid (illegal), the read is served first.
  - No request: stay in IDLE.
- READ_WAIT:
  - Hold mem_read_valid and mem_read_address stable.
  - On mem_read_ready==1: mem_read_valid<=0, consumer_read_data[grant]<=mem_read_data, consumer_read_ready[grant]<=1, go to RELEASE.
- WRITE_WAIT:
  - Hold mem_write_valid, mem_write_address and mem_write_data stable.
  - On mem_write_ready==1: mem_write_valid<=0, consumer_write_ready[grant]<=1, go to RELEASE.
- RELEASE:
  - Hold the ready bit high until the granted consumer's corresponding valid is sampled low.
  - Then clear the ready bit, set rr_ptr<=(grant_id+1) mod NUM_CONSUMERS, and go to IDLE.
- Latency:
  - Request sampled at edge E gives mem valid visible after E.
  - mem ready sampled at edge M gives consumer ready and data visible after M.
  - Minimum gap between back-to-back grants is one IDLE cycle.
- consumer_read_data[i] holds its value until overwritten by a later read for consumer i; it is never cleared except by reset.
- mem_*_ready while not in the matching WAIT state: ignored.
- A consumer dropping valid while in READ_WAIT or WRITE_WAIT (illegal): the memory transaction still completes. RELEASE then sees valid low and exits after one cycle.
- A request arriving during a non-IDLE state is not lost; it is arbitrated at the next IDLE.
- At most one bit of consumer_read_ready|consumer_write_ready is high at any time. mem_read_valid and mem_write_valid are never high together.

Test Plan:
- Single read: consumer 0 reads addr 0x10; memory asserts ready with data 0xAB 2 cycles after mem_read_valid -> mem_read_address=0x10; consumer_read_ready[0]=1 with consumer_read_data[0]=0xAB the cycle after ready; after consumer drops valid, ready falls and busy=0.
- Single write: consumer 3 writes 0x5C to 0x20 -> mem_write_address=0x20, mem_write_data=0x5C held until mem_write_ready; then consumer_write_ready[3] pulses and drops after the consumer's valid falls.
- Round-robin: consumers 0, 1 and 3 request reads simultaneously after reset -> service order 0,1,3. Consumer 0 re-requests during service of 1 -> next order 3,0.
- Starvation: all 4 consumers hold requests continuously for 8 transactions -> each is granted exactly twice, in order 0,1,2,3,0,1,2,3.
- Memory stall: mem_read_ready held low for 20 cycles -> mem_read_valid and address stay stable, busy=1, no consumer ready asserted.
- Reset mid-op: reset=0 while in READ_WAIT -> next cycle all outputs are 0, grant_id=0, and a subsequent request from consumer 2 is served normally.
